adder_arbiter: RTL
==================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, width of the completed-operation counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  requester n has an operation pending.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  requester n's operation is accepted this cycle.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH  operands of requester n.
REQ-008 SHALL have ports add_i_1, add_i_2  output  WIDTH  operands driven to the shared adder.
REQ-009 SHALL have port add_o  input  WIDTH  combinational sum returned by the shared adder.
REQ-010 SHALL have ports add_overflow, add_zero  input  1  adder carry-out and zero flags.
REQ-011 SHALL have port rsp_valid  output  1  a result is presented.
REQ-012 SHALL have port rsp_ready  input  1  consumer accepts the result.
REQ-013 SHALL have ports rsp_sum  output  WIDTH, rsp_overflow  output  1, rsp_zero  output  1  captured result and flags.
REQ-014 SHALL have port rsp_id  output  1  index of the requester that owns the result.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have port ops_done  output  CNT_W  count of completed response handshakes.

Function
REQ-017 SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-018 In IDLE, grant SHALL go to the only valid requester; if both are valid, grant SHALL go to the requester not served last (round-robin, 1-bit last_id).
REQ-019 reqN_ready SHALL be high only in IDLE and only for the granted requester; both readys never high together.
REQ-020 On reqN_valid & reqN_ready, the block SHALL register the operands of N, set owner id to N, update last_id to N, and enter EXEC.
REQ-021 In EXEC (exactly one cycle), add_i_1/add_i_2 SHALL equal the registered operands; at the end of EXEC add_o, add_overflow and add_zero SHALL be captured into rsp_sum/rsp_overflow/rsp_zero, and state SHALL go to RESP.
REQ-022 add_i_1/add_i_2 SHALL always be driven from the operand registers; they change only on request acceptance.
REQ-023 In RESP, rsp_valid SHALL be high and rsp_sum, rsp_overflow, rsp_zero and rsp_id SHALL be held stable until rsp_ready is sampled high.
REQ-024 On rsp_valid & rsp_ready, state SHALL return to IDLE, rsp_valid SHALL drop the next cycle, and ops_done SHALL increment by 1, wrapping from all-ones to 0.
REQ-025 No request SHALL be accepted in EXEC or RESP; minimum accept-to-accept spacing is 3 cycles (accept, EXEC, RESP with immediate rsp_ready).
REQ-026 Latency SHALL be 2 cycles: operation accepted in cycle T gives rsp_valid high in cycle T+2.
REQ-027 A requester dropping valid while not granted SHALL have no effect; arbitration SHALL be re-evaluated every IDLE cycle.
REQ-028 Sum width SHALL be WIDTH; carry beyond WIDTH SHALL appear only as rsp_overflow.

Reset
REQ-029 While rst is high: state IDLE, last_id 1 (so req0 wins the first tie), operand registers 0, rsp_sum 0, rsp_overflow 0, rsp_zero 0, rsp_id 0, rsp_valid 0, busy 0, ops_done 0.
REQ-030 Reset asserted in EXEC or RESP SHALL abort the operation immediately with no response and no ops_done increment.
REQ-031 After reset deassertion, the first IDLE cycle SHALL be able to accept a request.

Verification
REQ-032 Single op: req0 a=5, b=7, rsp_ready=1 -> rsp_valid at T+2, rsp_sum=12, rsp_id=0, overflow=0, zero=0, ops_done=1.
REQ-033 Tie: req0 and req1 valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0, one accept per 3 cycles.
REQ-034 Overflow/zero: req1 a=0xFFFFFFFF, b=1 -> rsp_sum=0, rsp_overflow=1, rsp_zero=1, rsp_id=1.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp outputs stable, both readys low, busy=1; accept on 6th cycle.
REQ-036 Mid-op reset: rst pulse in EXEC -> rsp_valid stays 0, ops_done=0, next req0 wins tie.
REQ-037 Counter wrap with CNT_W=2: 5 completed ops -> ops_done reads 1.

Source files
------------

// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end for a shared external combinational adder.
// Accept->rsp_valid latency 2 cycles; response held until rsp_ready, no accepts while busy.
module adder_arbiter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic             req1_valid,
   output logic             req0_ready,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [WIDTH-1:0] add_i_1,
   output logic [WIDTH-1:0] add_i_2,
   input  logic [WIDTH-1:0] add_o,
   input  logic             add_overflow,
   input  logic             add_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_overflow,
   output logic             rsp_zero,
   output logic             rsp_id,
   output logic             busy,
   output logic [CNT_W-1:0] ops_done
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t             r_state;
   logic               r_last_id;
   logic               r_owner;
   logic [WIDTH-1:0]   r_op_a;
   logic [WIDTH-1:0]   r_op_b;
   logic [WIDTH-1:0]   r_sum;
   logic               r_ovf;
   logic               r_zero;
   logic               r_rsp_valid;
   logic               r_busy;
   logic [CNT_W-1:0]   r_ops_done;

   logic               w_idle;
   logic               w_gnt_vld;
   logic               w_gnt_id;
   logic [CNT_W-1:0]   w_one;

   assign w_one     = {{(CNT_W-1){1'b0}}, 1'b1};
   assign w_idle    = (r_state == IDLE);
   assign w_gnt_vld = req0_valid | req1_valid;
   // On a tie the requester not served last wins; otherwise the lone valid one.
   assign w_gnt_id  = (req0_valid & req1_valid) ? ~r_last_id : req1_valid;

   assign req0_ready = w_idle & w_gnt_vld & ~w_gnt_id;
   assign req1_ready = w_idle & w_gnt_vld &  w_gnt_id;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_last_id   <= 1'b1;
         r_owner     <= 1'b0;
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_sum       <= '0;
         r_ovf       <= 1'b0;
         r_zero      <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_ops_done  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_gnt_vld) begin
                  r_op_a    <= w_gnt_id ? req1_a : req0_a;
                  r_op_b    <= w_gnt_id ? req1_b : req0_b;
                  r_owner   <= w_gnt_id;
                  r_last_id <= w_gnt_id;
                  r_busy    <= 1'b1;
                  r_state   <= EXEC;
               end
            end
            EXEC: begin
               r_sum       <= add_o;
               r_ovf       <= add_overflow;
               r_zero      <= add_zero;
               r_rsp_valid <= 1'b1;
               r_state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_ops_done  <= r_ops_done + w_one;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_rsp_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign add_i_1      = r_op_a;
   assign add_i_2      = r_op_b;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_sum      = r_sum;
   assign rsp_overflow = r_ovf;
   assign rsp_zero     = r_zero;
   assign rsp_id       = r_owner;
   assign busy         = r_busy;
   assign ops_done     = r_ops_done;

endmodule
